hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/mips_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hazard_state_t;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

  // One bit per pipeline control line, so a whole decision can be gated at once.
  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic ifid_flush;
    logic idex_null;
    logic memwb_null;
    logic mem_err;
  } hazard_ctl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: the instruction in ID reads a register that the
// load currently in EX has not yet written. Register 0 never creates a dependency.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_memrd,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_use_rs && (id_rs == ex_rt);
    rt_match = id_use_rt && (id_rt == ex_rt);
    load_use = ex_memrd && (ex_rt != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flushes, data-memory wait with timeout.
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_count statistics outputs.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_memrd,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_hold,
  output logic        ifid_hold,
  output logic        idex_hold,
  output logic        exmem_hold,
  output logic        ifid_flush,
  output logic        idex_null,
  output logic        memwb_null,
  output logic        mem_err,
  output logic [1:0]  state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  hazard_state_t state_q, state_d;
  logic [7:0]    wait_cnt, wait_cnt_d;
  logic          lu_done_q, lu_done_d;
  logic          load_use;
  logic          mem_stall;
  hazard_ctl_t   ctl;
  hazard_ctl_t   ctl_o;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  load_use_detect u_load_use_detect (
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .ex_memrd  (ex_memrd),
    .ex_rt     (ex_rt),
    .load_use  (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // RUN and MEM_WAIT share one priority chain; they differ only in where they go next.
  always_comb begin
    ctl        = '0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt;
    lu_done_d  = 1'b0;
    case (state_q)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          ctl.pc_hold    = 1'b1;
          ctl.ifid_hold  = 1'b1;
          ctl.idex_hold  = 1'b1;
          ctl.exmem_hold = 1'b1;
          ctl.memwb_null = 1'b1;
        end else if (ex_branch_taken) begin
          ctl.ifid_flush = 1'b1;
          ctl.idex_null  = 1'b1;
        end else if (load_use && !lu_done_q) begin
          // One bubble per occurrence: the cycle after a stall never re-stalls.
          ctl.pc_hold   = 1'b1;
          ctl.ifid_hold = 1'b1;
          ctl.idex_null = 1'b1;
          lu_done_d     = 1'b1;
        end else if (id_jump) begin
          ctl.ifid_flush = 1'b1;
        end

        if (state_q == RUN) begin
          if (mem_stall) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = 8'd1;
          end
        end else if (mem_stall) begin
          wait_cnt_d = sat_inc8(wait_cnt);
          if (wait_cnt == TIMEOUT_CNT) begin
            state_d = ERROR;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERROR: begin
        ctl.pc_hold    = 1'b1;
        ctl.ifid_hold  = 1'b1;
        ctl.idex_hold  = 1'b1;
        ctl.exmem_hold = 1'b1;
        ctl.memwb_null = 1'b1;
        ctl.mem_err    = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_cnt  <= '0;
      lu_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_cnt  <= wait_cnt_d;
      lu_done_q <= lu_done_d;
    end
  end

  // Reset silences every control line immediately, whatever the inputs are doing.
  assign ctl_o      = reset ? '0 : ctl;
  assign pc_hold    = ctl_o.pc_hold;
  assign ifid_hold  = ctl_o.ifid_hold;
  assign idex_hold  = ctl_o.idex_hold;
  assign exmem_hold = ctl_o.exmem_hold;
  assign ifid_flush = ctl_o.ifid_flush;
  assign idex_null  = ctl_o.idex_null;
  assign memwb_null = ctl_o.memwb_null;
  assign mem_err    = ctl_o.mem_err;
  assign state_o    = state_q;

`ifdef HAZARD_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (ctl.pc_hold) begin
        stall_cycles <= sat_inc32(stall_cycles);
      end
      if (ctl.ifid_flush) begin
        flush_count <= sat_inc32(flush_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios pinned to literal values, then
// randomized traffic checked every cycle against a behavioural model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;

  // {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_null, memwb_null, mem_err, state[1:0]}
  localparam logic [9:0] O_ZERO    = 10'b0000000000;
  localparam logic [9:0] O_LU      = 10'b1100010000;
  localparam logic [9:0] O_BR      = 10'b0000110000;
  localparam logic [9:0] O_JMP     = 10'b0000100000;
  localparam logic [9:0] O_MEMRUN  = 10'b1111001000;
  localparam logic [9:0] O_MEMWAIT = 10'b1111001001;
  localparam logic [9:0] O_ERR     = 10'b1111001110;
  localparam logic [9:0] O_RELEASE = 10'b0000000001;
  localparam logic [9:0] CTL_MASK  = 10'b1111111100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_use_rs, id_use_rt, ex_memrd, ex_branch_taken, id_jump, mem_req, mem_ready;
  logic       pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_null, memwb_null, mem_err;
  logic [1:0] state_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
  logic [31:0] m_stall, m_flush;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Model state: consecutive cycles the current memory access has stalled, sticky error,
  // and whether the previous cycle issued a load-use bubble.
  int m_run;
  bit m_err;
  bit m_prev_lu;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_use_rs       (id_use_rs),
    .id_use_rt       (id_use_rt),
    .ex_memrd        (ex_memrd),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .id_jump         (id_jump),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .idex_hold       (idex_hold),
    .exmem_hold      (exmem_hold),
    .ifid_flush      (ifid_flush),
    .idex_null       (idex_null),
    .memwb_null      (memwb_null),
    .mem_err         (mem_err),
    .state_o         (state_o)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  function automatic logic [9:0] model_out();
    logic [9:0] st;
    bit lu;
    if (reset) return O_ZERO;
    if (m_err) return O_ERR;
    st = (m_run > 0) ? 10'd1 : 10'd0;
    lu = ex_memrd && (ex_rt != 5'd0) &&
         ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    if (mem_req && !mem_ready) return O_MEMRUN | st;
    if (ex_branch_taken) return O_BR | st;
    if (lu && !m_prev_lu) return O_LU | st;
    if (id_jump) return O_JMP | st;
    return st;
  endfunction

  task automatic model_step(input logic [9:0] o);
    if (reset) begin
      m_run = 0;
      m_err = 1'b0;
      m_prev_lu = 1'b0;
`ifdef HAZARD_STATS_EN
      m_stall = '0;
      m_flush = '0;
`endif
      return;
    end
`ifdef HAZARD_STATS_EN
    if (o[9]) m_stall = m_stall + 32'd1;
    if (o[5]) m_flush = m_flush + 32'd1;
`endif
    m_prev_lu = ((o & CTL_MASK) == O_LU);
    if (!m_err) begin
      if (mem_req && !mem_ready) begin
        m_run++;
        if (m_run > TIMEOUT) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are already applied; sample at the falling edge, then advance past the rising edge.
  task automatic cycle(input string name, input bit use_lit, input logic [9:0] lit);
    logic [9:0] exp_v;
    logic [9:0] act_v;
    @(negedge clk);
    exp_v = model_out();
    act_v = {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_null,
             memwb_null, mem_err, state_o};
    check(name, {22'd0, act_v}, {22'd0, exp_v});
    if (use_lit) check({name, "_lit"}, {22'd0, act_v}, {22'd0, lit});
`ifdef HAZARD_STATS_EN
    check("stall_cycles", stall_cycles, reset ? 32'd0 : m_stall);
    check("flush_count", flush_count, reset ? 32'd0 : m_flush);
`endif
    model_step(exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memrd = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    m_run = 0; m_err = 1'b0; m_prev_lu = 1'b0;
`ifdef HAZARD_STATS_EN
    m_stall = '0; m_flush = '0;
`endif
    @(posedge clk);
    #1;
    ex_memrd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1; mem_req = 1'b1; id_jump = 1'b1;
    cycle("reset_forces_zero", 1'b1, O_ZERO);
    reset = 1'b0;
    set_idle();
    cycle("idle_after_reset", 1'b1, O_ZERO);

    ex_memrd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    cycle("load_use_stall", 1'b1, O_LU);
    ex_memrd = 1'b0;
    cycle("load_use_clear", 1'b1, O_ZERO);

    set_idle();
    id_jump = 1'b1; ex_memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_use_rs = 1'b1;
    cycle("jump_lu_stall", 1'b1, O_LU);
    cycle("jump_flush_next", 1'b1, O_JMP);
    set_idle();
`ifdef HAZARD_STATS_EN
    @(negedge clk);
    check("stall_cycles_lit", stall_cycles, 32'd2);
    check("flush_count_lit", flush_count, 32'd1);
    @(posedge clk);
    #1;
`endif
    cycle("idle_after_jump", 1'b1, O_ZERO);

    ex_memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    cycle("rt_zero_no_stall", 1'b1, O_ZERO);
    ex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
    cycle("branch_over_load_use", 1'b1, O_BR);

    set_idle();
    mem_req = 1'b1;
    cycle("mem_stall_enter", 1'b1, O_MEMRUN);
    cycle("mem_wait_1", 1'b1, O_MEMWAIT);
    cycle("mem_wait_2", 1'b1, O_MEMWAIT);
    mem_ready = 1'b1;
    cycle("mem_release", 1'b1, O_RELEASE);
    set_idle();
    cycle("run_after_release", 1'b1, O_ZERO);

    mem_req = 1'b1;
    cycle("timeout_enter", 1'b1, O_MEMRUN);
    for (int i = 0; i < TIMEOUT; i++) cycle("timeout_wait", 1'b1, O_MEMWAIT);
    cycle("error_entered", 1'b1, O_ERR);
    mem_req = 1'b0; mem_ready = 1'b1; ex_branch_taken = 1'b1;
    cycle("error_sticky", 1'b1, O_ERR);
    reset = 1'b1;
    cycle("error_reset", 1'b1, O_ZERO);
    reset = 1'b0;
    set_idle();
    cycle("run_after_error", 1'b1, O_ZERO);

    mem_req = 1'b1;
    cycle("wait2_enter", 1'b1, O_MEMRUN);
    cycle("wait2_wait", 1'b1, O_MEMWAIT);
    reset = 1'b1;
    cycle("reset_mid_wait", 1'b1, O_ZERO);
    reset = 1'b0;
    mem_req = 1'b0;
    cycle("run_after_mid_reset", 1'b1, O_ZERO);

    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 59) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_use_rs       = 1'($urandom_range(0, 1));
      id_use_rt       = 1'($urandom_range(0, 1));
      ex_memrd        = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_jump         = ($urandom_range(0, 4) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      mem_ready       = 1'($urandom_range(0, 1));
      cycle("random", 1'b0, O_ZERO);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
